// File: rtl/fetch_line_compare_pkg.sv
// Shared definitions for the fetch front-end: opcode map, instruction field layout,
// and the P/N/E condition-flag bundle.
package fetch_line_compare_pkg;

    localparam int LINE_W  = 64;
    localparam int WORD_W  = 16;
    localparam int OPC_W   = 7;
    localparam int OPER_W  = 3;
    localparam int RAW_W   = 15;

    // Opcodes strictly below this value are handled by the integer pipe (NOP included).
    localparam logic [OPC_W-1:0] INT_OP_LIMIT = 7'd11;

    // Field positions inside a 16-bit instruction word.
    localparam int OPC_MSB    = 15;
    localparam int OPC_LSB    = 9;
    localparam int OPER_A_MSB = 8;
    localparam int OPER_A_LSB = 6;
    localparam int OPER_B_MSB = 5;
    localparam int OPER_B_LSB = 3;
    localparam int OPER_C_MSB = 2;
    localparam int OPER_C_LSB = 0;
    localparam int LDL_BIT    = 15;

    typedef enum logic [OPC_W-1:0] {
        OP_SSR   = 7'd40,
        OP_LSR   = 7'd41,
        OP_PUSH  = 7'd42,
        OP_POP   = 7'd43,
        OP_CALL  = 7'd44,
        OP_RET   = 7'd45,
        OP_CMP   = 7'd50,
        OP_JMP   = 7'd51,
        OP_JE    = 7'd52,
        OP_JP    = 7'd53,
        OP_JN    = 7'd54,
        OP_HLT   = 7'd59,
        OP_LOAD  = 7'd60,
        OP_STORE = 7'd61
    } opcode_e;

    typedef struct packed {
        logic p;
        logic n;
        logic e;
    } flags_t;

    function automatic logic is_int_op(input logic [OPC_W-1:0] opc);
        return opc < INT_OP_LIMIT;
    endfunction

endpackage

// File: rtl/fetch_line_compare_line_breaker.sv
// Selects one 16-bit instruction word out of a 64-bit I-cache line; word 0 sits in the
// least-significant lane.
module fetch_line_compare_line_breaker
    import fetch_line_compare_pkg::*;
(
    input  logic [1:0]        offset,
    input  logic [LINE_W-1:0] cache_dat,
    output logic [WORD_W-1:0] cur_op
);

    always_comb begin
        // NOTE: the default assignment first keeps this block latch-free even if the case is edited later.
        cur_op = cache_dat[15:0];
        unique case (offset)
            2'd0: cur_op = cache_dat[15:0];
            2'd1: cur_op = cache_dat[31:16];
            2'd2: cur_op = cache_dat[47:32];
            2'd3: cur_op = cache_dat[63:48];
            default: cur_op = cache_dat[15:0];
        endcase
    end

endmodule

// File: rtl/fetch_line_compare.sv
// Fetch/dispatch helper: picks the current instruction from the cache line, decodes its
// fields, compares two register operands unsigned and holds the P/N/E flags set by CMP.
module fetch_line_compare
    import fetch_line_compare_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          offset,
    input  logic [LINE_W-1:0]   cache_dat,
    input  logic [WORD_W-1:0]   a_dat,
    input  logic [WORD_W-1:0]   b_dat,
    input  logic                cmp_en,
    output logic [WORD_W-1:0]   cur_op,
    output logic [OPC_W-1:0]    opcode,
    output logic [OPER_W-1:0]   oper_a,
    output logic [OPER_W-1:0]   oper_b,
    output logic [OPER_W-1:0]   oper_c,
    output logic                ldl_bit,
    output logic [RAW_W-1:0]    raw_data,
    output logic                int_op,
    output logic                grtr,
    output logic                less,
    output logic                same,
    output logic                flag_p,
    output logic                flag_n,
    output logic                flag_e
);

    logic [WORD_W-1:0] w_cur_op;
    flags_t            w_cmp;
    flags_t            r_flags;

    fetch_line_compare_line_breaker u_line_breaker (
        .offset    (offset),
        .cache_dat (cache_dat),
        .cur_op    (w_cur_op)
    );

    assign cur_op   = w_cur_op;
    assign opcode   = w_cur_op[OPC_MSB:OPC_LSB];
    assign oper_a   = w_cur_op[OPER_A_MSB:OPER_A_LSB];
    assign oper_b   = w_cur_op[OPER_B_MSB:OPER_B_LSB];
    assign oper_c   = w_cur_op[OPER_C_MSB:OPER_C_LSB];
    assign ldl_bit  = w_cur_op[LDL_BIT];
    assign raw_data = w_cur_op[RAW_W-1:0];
    assign int_op   = is_int_op(w_cur_op[OPC_MSB:OPC_LSB]);

    // Unsigned compare: 16'hFFFF is the largest value, not -1.
    assign w_cmp.p = a_dat > b_dat;
    assign w_cmp.n = a_dat < b_dat;
    assign w_cmp.e = a_dat == b_dat;

    assign grtr = w_cmp.p;
    assign less = w_cmp.n;
    assign same = w_cmp.e;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_flags <= '0;
        end else if (cmp_en) begin
            r_flags <= w_cmp;
        end
    end

    assign flag_p = r_flags.p;
    assign flag_n = r_flags.n;
    assign flag_e = r_flags.e;

endmodule

// File: tb/tb_fetch_line_compare.sv
// Directed bench for fetch_line_compare: a table of combinational vectors followed by
// hand-written flag/reset sequences.
module tb_fetch_line_compare;

    logic        clk;
    logic        rst;
    logic [1:0]  offset;
    logic [63:0] cache_dat;
    logic [15:0] a_dat;
    logic [15:0] b_dat;
    logic        cmp_en;
    logic [15:0] cur_op;
    logic [6:0]  opcode;
    logic [2:0]  oper_a;
    logic [2:0]  oper_b;
    logic [2:0]  oper_c;
    logic        ldl_bit;
    logic [14:0] raw_data;
    logic        int_op;
    logic        grtr;
    logic        less;
    logic        same;
    logic        flag_p;
    logic        flag_n;
    logic        flag_e;

    int n_checks = 0;
    int n_fails  = 0;

    fetch_line_compare dut (
        .clk       (clk),
        .rst       (rst),
        .offset    (offset),
        .cache_dat (cache_dat),
        .a_dat     (a_dat),
        .b_dat     (b_dat),
        .cmp_en    (cmp_en),
        .cur_op    (cur_op),
        .opcode    (opcode),
        .oper_a    (oper_a),
        .oper_b    (oper_b),
        .oper_c    (oper_c),
        .ldl_bit   (ldl_bit),
        .raw_data  (raw_data),
        .int_op    (int_op),
        .grtr      (grtr),
        .less      (less),
        .same      (same),
        .flag_p    (flag_p),
        .flag_n    (flag_n),
        .flag_e    (flag_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  off;
        logic [63:0] line;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] e_op;
        logic [6:0]  e_opc;
        logic [2:0]  e_a;
        logic [2:0]  e_b;
        logic [2:0]  e_c;
        logic        e_ldl;
        logic [14:0] e_raw;
        logic        e_int;
        logic [2:0]  e_gls;   // {grtr, less, same}
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_flags(input string name, input logic [2:0] exp_pne);
        check({name, " flags"}, {61'd0, flag_p, flag_n, flag_e}, {61'd0, exp_pne});
    endtask

    initial begin
        vecs[0]  = '{2'd0, 64'h4444_3333_2222_1111, 16'h0005, 16'h0003, 16'h1111, 7'd8,  3'd4, 3'd2, 3'd1, 1'b0, 15'h1111, 1'b1, 3'b100};
        vecs[1]  = '{2'd1, 64'h4444_3333_2222_1111, 16'h0003, 16'h0005, 16'h2222, 7'd17, 3'd0, 3'd4, 3'd2, 1'b0, 15'h2222, 1'b0, 3'b010};
        vecs[2]  = '{2'd2, 64'h4444_3333_2222_1111, 16'h1234, 16'h1234, 16'h3333, 7'd25, 3'd4, 3'd6, 3'd3, 1'b0, 15'h3333, 1'b0, 3'b001};
        vecs[3]  = '{2'd3, 64'h4444_3333_2222_1111, 16'hFFFF, 16'h0001, 16'h4444, 7'd34, 3'd1, 3'd0, 3'd4, 1'b0, 15'h4444, 1'b0, 3'b100};
        vecs[4]  = '{2'd0, 64'h0000_0000_0000_A5C3, 16'h0000, 16'h0000, 16'hA5C3, 7'h52, 3'd7, 3'd0, 3'd3, 1'b1, 15'h25C3, 1'b0, 3'b001};
        vecs[5]  = '{2'd2, 64'hFFFF_0000_FFFF_FFFF, 16'hFFFF, 16'h0000, 16'h0000, 7'd0,  3'd0, 3'd0, 3'd0, 1'b0, 15'h0000, 1'b1, 3'b100};
        vecs[6]  = '{2'd3, 64'h1400_AAAA_BBBB_CCCC, 16'h0001, 16'hFFFF, 16'h1400, 7'd10, 3'd0, 3'd0, 3'd0, 1'b0, 15'h1400, 1'b1, 3'b010};
        vecs[7]  = '{2'd1, 64'h0000_0000_1600_0000, 16'h8000, 16'h7FFF, 16'h1600, 7'd11, 3'd0, 3'd0, 3'd0, 1'b0, 15'h1600, 1'b0, 3'b100};
        vecs[8]  = '{2'd0, 64'h0000_0000_0000_6400, 16'hFFFF, 16'hFFFF, 16'h6400, 7'd50, 3'd0, 3'd0, 3'd0, 1'b0, 15'h6400, 1'b0, 3'b001};
        vecs[9]  = '{2'd2, 64'h0000_FE00_0000_0000, 16'h0000, 16'h0001, 16'hFE00, 7'd127,3'd0, 3'd0, 3'd0, 1'b1, 15'h7E00, 1'b0, 3'b010};
        vecs[10] = '{2'd3, 64'hFFFF_0000_0000_0000, 16'h0001, 16'h0000, 16'hFFFF, 7'd127,3'd7, 3'd7, 3'd7, 1'b1, 15'h7FFF, 1'b0, 3'b100};

        rst       = 1'b1;
        cmp_en    = 1'b0;
        offset    = 2'd0;
        cache_dat = 64'd0;
        a_dat     = 16'd0;
        b_dat     = 16'd0;
        @(negedge clk);
        step();
        rst = 1'b0;
        check_flags("reset", 3'b000);

        // Combinational table; flags are left untouched (cmp_en low).
        for (int i = 0; i < 11; i++) begin
            offset    = vecs[i].off;
            cache_dat = vecs[i].line;
            a_dat     = vecs[i].a;
            b_dat     = vecs[i].b;
            #1;
            check($sformatf("v%0d cur_op", i),   {48'd0, cur_op},   {48'd0, vecs[i].e_op});
            check($sformatf("v%0d opcode", i),   {57'd0, opcode},   {57'd0, vecs[i].e_opc});
            check($sformatf("v%0d oper_a", i),   {61'd0, oper_a},   {61'd0, vecs[i].e_a});
            check($sformatf("v%0d oper_b", i),   {61'd0, oper_b},   {61'd0, vecs[i].e_b});
            check($sformatf("v%0d oper_c", i),   {61'd0, oper_c},   {61'd0, vecs[i].e_c});
            check($sformatf("v%0d ldl_bit", i),  {63'd0, ldl_bit},  {63'd0, vecs[i].e_ldl});
            check($sformatf("v%0d raw_data", i), {49'd0, raw_data}, {49'd0, vecs[i].e_raw});
            check($sformatf("v%0d int_op", i),   {63'd0, int_op},   {63'd0, vecs[i].e_int});
            check($sformatf("v%0d gls", i),      {61'd0, grtr, less, same}, {61'd0, vecs[i].e_gls});
        end
        @(negedge clk);
        check_flags("hold through table", 3'b000);

        // CMP a<b latches N one cycle later.
        a_dat = 16'd7; b_dat = 16'd9; cmp_en = 1'b1;
        #1;
        check_flags("before latch", 3'b000);
        step();
        cmp_en = 1'b0;
        check_flags("cmp 7 vs 9", 3'b010);

        // Operands change without cmp_en: flags hold.
        a_dat = 16'd9; b_dat = 16'd7;
        step();
        check_flags("hold", 3'b000 | 3'b010);

        a_dat = 16'h0055; b_dat = 16'h0055; cmp_en = 1'b1;
        step();
        check_flags("cmp equal", 3'b001);

        // Reset wins over cmp_en; combinational compare keeps tracking during reset.
        a_dat = 16'd9; b_dat = 16'd1; cmp_en = 1'b1; rst = 1'b1;
        #1;
        check("grtr during rst", {63'd0, grtr}, 64'd1);
        step();
        check_flags("rst over cmp_en", 3'b000);
        rst = 1'b0; cmp_en = 1'b0;
        step();
        check_flags("after rst idle", 3'b000);

        // Unsigned boundary through the flag path.
        a_dat = 16'hFFFF; b_dat = 16'h0000; cmp_en = 1'b1;
        step();
        cmp_en = 1'b0;
        check_flags("cmp FFFF vs 0", 3'b100);

        a_dat = 16'h0000; b_dat = 16'h0000; cmp_en = 1'b1;
        step();
        cmp_en = 1'b0;
        check_flags("cmp 0 vs 0", 3'b001);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule
